// File: rtl/dp_lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dp_lookup_pkg
// Purpose : Shared definitions for the data-path ternary lookup stage.
//           - Config header field offsets, measured down from the tdata MSB.
//           - Config FSM state encoding.
//           - Saturating 32-bit add used by the optional statistics
//             counters (enabled by the DP_TCAM_STATS_EN macro).
// Revision: 1.0 - initial release
// ============================================================================
package dp_lookup_pkg;

  // Header field widths
  localparam int HDR_ID_W  = 12;
  localparam int HDR_IDX_W = 8;

  // Header field MSB offsets below tdata[W-1]
  localparam int HDR_ID_OFF  = 0;   // tdata[W-1  -: 12]
  localparam int HDR_IDX_OFF = 12;  // tdata[W-13 -: 8]
  localparam int HDR_VLD_OFF = 20;  // tdata[W-21]
  localparam int HDR_CLR_OFF = 21;  // tdata[W-22]

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HDR_OK    = 2'd1,
    ST_GOT_VAL   = 2'd2,
    ST_WAIT_LAST = 2'd3
  } cfg_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_tcam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : dp_tcam_prio_enc
// Purpose : Combinational lowest-index priority encoder.
// Ports   : vec  in  DEPTH - hit vector, bit e = entry e matched
//           hit  out 1     - any bit set
//           addr out AW    - index of lowest set bit (0 when none)
// Revision: 1.0 - initial release
// ============================================================================
module dp_tcam_prio_enc #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic             hit,
  output logic [AW-1:0]    addr
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    hit  = |vec;
    addr = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (vec[e]) addr = AW'(e);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dp_tcam_lookup_mc.sv
`default_nettype none
// ============================================================================
// Module  : dp_tcam_lookup_mc
// Purpose : Multi-channel ternary lookup. A TCAM_DEPTH x KEY_WIDTH value/mask
//           table is written by in-band control packets (header, value,
//           mask) addressed to CFG_TCAM_MOD_ID; NUM_CH key streams are
//           matched against it every cycle, lowest matching index wins.
// Ports   : axis_clk, aresetn        - clock, async active-low reset
//           ctrl_s_axis_*            - control stream in
//           ctrl_m_axis_*            - control stream out (1-cycle register)
//           i_dp_bit/_mask/_valid    - per-channel key, care bits, strobe
//           o_dp_tcam_match/_addr/_valid - per-channel result (2-cycle)
//           o_hit_cnt, o_miss_cnt    - only when DP_TCAM_STATS_EN defined
// Macro   : DP_TCAM_STATS_EN - adds saturating hit/miss counters and the
//           header clear bit.
// Revision: 1.0 - initial release
// ============================================================================
module dp_tcam_lookup_mc
  import dp_lookup_pkg::*;
#(
  parameter int                C_AXIS_DATA_WIDTH  = 256,
  parameter int                C_AXIS_TUSER_WIDTH = 128,
  parameter int                KEY_WIDTH          = 128,
  parameter int                TCAM_DEPTH         = 32,
  parameter int                ADDR_WIDTH         = $clog2(TCAM_DEPTH),
  parameter int                NUM_CH             = 2,
  parameter logic [HDR_ID_W-1:0] CFG_TCAM_MOD_ID  = 12'd8
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic                            ctrl_s_axis_tvalid,
  input  logic                            ctrl_s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
  output logic                            ctrl_m_axis_tvalid,
  output logic                            ctrl_m_axis_tlast,
  input  logic [NUM_CH*KEY_WIDTH-1:0]     i_dp_bit,
  input  logic [NUM_CH*KEY_WIDTH-1:0]     i_dp_bit_mask,
  input  logic [NUM_CH-1:0]               i_dp_bit_valid,
  output logic [NUM_CH-1:0]               o_dp_tcam_match,
  output logic [NUM_CH*ADDR_WIDTH-1:0]    o_dp_tcam_match_addr,
  output logic [NUM_CH-1:0]               o_dp_tcam_match_valid
`ifdef DP_TCAM_STATS_EN
  ,output logic [31:0]                    o_hit_cnt
  ,output logic [31:0]                    o_miss_cnt
`endif
);

  localparam int W = C_AXIS_DATA_WIDTH;

  // ---------------- control passthrough ----------------
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_m_axis_tdata  <= '0;
      ctrl_m_axis_tuser  <= '0;
      ctrl_m_axis_tkeep  <= '0;
      ctrl_m_axis_tvalid <= 1'b0;
      ctrl_m_axis_tlast  <= 1'b0;
    end else begin
      ctrl_m_axis_tdata  <= ctrl_s_axis_tdata;
      ctrl_m_axis_tuser  <= ctrl_s_axis_tuser;
      ctrl_m_axis_tkeep  <= ctrl_s_axis_tkeep;
      ctrl_m_axis_tvalid <= ctrl_s_axis_tvalid;
      ctrl_m_axis_tlast  <= ctrl_s_axis_tlast;
    end
  end

  // ---------------- header decode ----------------
  logic [HDR_ID_W-1:0]  hdr_id;
  logic [HDR_IDX_W-1:0] hdr_idx;
  logic                 hdr_vld, id_ok, idx_ok;

  assign hdr_id  = ctrl_s_axis_tdata[W-1-HDR_ID_OFF -: HDR_ID_W];
  assign hdr_idx = ctrl_s_axis_tdata[W-1-HDR_IDX_OFF -: HDR_IDX_W];
  assign hdr_vld = ctrl_s_axis_tdata[W-1-HDR_VLD_OFF];
  assign id_ok   = (hdr_id == CFG_TCAM_MOD_ID);
  assign idx_ok  = ({1'b0, hdr_idx} < (HDR_IDX_W+1)'(TCAM_DEPTH));

  // ---------------- config FSM ----------------
  cfg_state_e state, state_nxt;
  logic       hdr_cap, val_cap, mask_cap;
  logic       full, full_nxt;     // beats 0-2 all seen in this packet
  logic       commit, commit_nxt;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ST_IDLE;
      full   <= 1'b0;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      full   <= full_nxt;
      commit <= commit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    full_nxt   = full;
    commit_nxt = 1'b0;
    hdr_cap    = 1'b0;
    val_cap    = 1'b0;
    mask_cap   = 1'b0;
    if (ctrl_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          full_nxt = 1'b0;
          if (id_ok && idx_ok) begin
            hdr_cap   = 1'b1;
            state_nxt = ST_HDR_OK;
          end else begin
            state_nxt = ST_WAIT_LAST;
          end
        end
        ST_HDR_OK: begin
          val_cap   = 1'b1;
          state_nxt = ST_GOT_VAL;
        end
        ST_GOT_VAL: begin
          mask_cap   = 1'b1;
          full_nxt   = 1'b1;
          commit_nxt = ctrl_s_axis_tlast;
          state_nxt  = ST_WAIT_LAST;
        end
        default: begin
          commit_nxt = ctrl_s_axis_tlast && full;
        end
      endcase
      // Any last beat ends the packet regardless of where the FSM was.
      if (ctrl_s_axis_tlast) begin
        state_nxt = ST_IDLE;
        full_nxt  = 1'b0;
      end
    end
  end

  // ---------------- staging and live table ----------------
  logic [ADDR_WIDTH-1:0] stg_idx;
  logic                  stg_vld;
  logic [KEY_WIDTH-1:0]  stg_val, stg_mask;
  logic [KEY_WIDTH-1:0]  tbl_val  [TCAM_DEPTH];
  logic [KEY_WIDTH-1:0]  tbl_mask [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0] tbl_vld;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      stg_idx  <= '0;
      stg_vld  <= 1'b0;
      stg_val  <= '0;
      stg_mask <= '0;
    end else begin
      if (hdr_cap) begin
        stg_idx <= hdr_idx[ADDR_WIDTH-1:0];
        stg_vld <= hdr_vld;
      end
      if (val_cap)  stg_val  <= ctrl_s_axis_tdata[KEY_WIDTH-1:0];
      if (mask_cap) stg_mask <= ctrl_s_axis_tdata[KEY_WIDTH-1:0];
    end
  end

  // Commit reads staging before a back-to-back header can overwrite it.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      tbl_vld <= '0;
      for (int e = 0; e < TCAM_DEPTH; e++) begin
        tbl_val[e]  <= '0;
        tbl_mask[e] <= '0;
      end
    end else if (commit) begin
      tbl_vld[stg_idx]  <= stg_vld;
      tbl_val[stg_idx]  <= stg_val;
      tbl_mask[stg_idx] <= stg_mask;
    end
  end

  // ---------------- lookup pipeline ----------------
  logic [TCAM_DEPTH-1:0] hit_c  [NUM_CH];
  logic [TCAM_DEPTH-1:0] hit_s1 [NUM_CH];
  logic [NUM_CH-1:0]     vld_s1;
  logic                  enc_hit  [NUM_CH];
  logic [ADDR_WIDTH-1:0] enc_addr [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < TCAM_DEPTH; e++) begin
        hit_c[c][e] = tbl_vld[e] &&
          (((i_dp_bit[c*KEY_WIDTH +: KEY_WIDTH] ^ tbl_val[e]) & tbl_mask[e] &
            i_dp_bit_mask[c*KEY_WIDTH +: KEY_WIDTH]) == '0);
      end
    end
  end

  // Idle channels load an all-zero vector so stage 2 reports match=0/addr=0.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_s1 <= '0;
      for (int c = 0; c < NUM_CH; c++) hit_s1[c] <= '0;
    end else begin
      vld_s1 <= i_dp_bit_valid;
      for (int c = 0; c < NUM_CH; c++)
        hit_s1[c] <= i_dp_bit_valid[c] ? hit_c[c] : '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dp_tcam_prio_enc #(
      .DEPTH (TCAM_DEPTH),
      .AW    (ADDR_WIDTH)
    ) u_enc (
      .vec  (hit_s1[c]),
      .hit  (enc_hit[c]),
      .addr (enc_addr[c])
    );
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      o_dp_tcam_match       <= '0;
      o_dp_tcam_match_addr  <= '0;
      o_dp_tcam_match_valid <= '0;
    end else begin
      o_dp_tcam_match_valid <= vld_s1;
      for (int c = 0; c < NUM_CH; c++) begin
        o_dp_tcam_match[c]                               <= enc_hit[c];
        o_dp_tcam_match_addr[c*ADDR_WIDTH +: ADDR_WIDTH] <= enc_addr[c];
      end
    end
  end

`ifdef DP_TCAM_STATS_EN
  // ---------------- statistics ----------------
  logic        clr_stats;
  logic [31:0] hit_inc, miss_inc;

  // Clear bit is honoured on any header for this module, even a
  // one-beat packet.
  assign clr_stats = ctrl_s_axis_tvalid && (state == ST_IDLE) && id_ok &&
                     ctrl_s_axis_tdata[W-1-HDR_CLR_OFF];

  always_comb begin
    hit_inc  = '0;
    miss_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (vld_s1[c]) begin
        if (enc_hit[c]) hit_inc  = hit_inc + 32'd1;
        else            miss_inc = miss_inc + 32'd1;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (clr_stats) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      o_hit_cnt  <= sat_add32(o_hit_cnt, hit_inc);
      o_miss_cnt <= sat_add32(o_miss_cnt, miss_inc);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_tcam_lookup_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_dp_tcam_lookup_mc
// Purpose : Directed self-checking bench for dp_tcam_lookup_mc with default
//           parameters (W=256, KEY=128, DEPTH=32, NUM_CH=2, ID=8).
//           Counter checks are included when DP_TCAM_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dp_tcam_lookup_mc;

  localparam int W   = 256;
  localparam int TU  = 128;
  localparam int KW  = 128;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      s_tdata = '0;
  logic [TU-1:0]     s_tuser = '0;
  logic [W/8-1:0]    s_tkeep = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic [W-1:0]      m_tdata;
  logic [TU-1:0]     m_tuser;
  logic [W/8-1:0]    m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic [NCH*KW-1:0] key = '0;
  logic [NCH*KW-1:0] keymask = '0;
  logic [NCH-1:0]    key_vld = '0;
  logic [NCH-1:0]    match;
  logic [NCH*AW-1:0] maddr;
  logic [NCH-1:0]    mvalid;
`ifdef DP_TCAM_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dp_tcam_lookup_mc dut (
    .axis_clk              (clk),
    .aresetn               (rst_n),
    .ctrl_s_axis_tdata     (s_tdata),
    .ctrl_s_axis_tuser     (s_tuser),
    .ctrl_s_axis_tkeep     (s_tkeep),
    .ctrl_s_axis_tvalid    (s_tvalid),
    .ctrl_s_axis_tlast     (s_tlast),
    .ctrl_m_axis_tdata     (m_tdata),
    .ctrl_m_axis_tuser     (m_tuser),
    .ctrl_m_axis_tkeep     (m_tkeep),
    .ctrl_m_axis_tvalid    (m_tvalid),
    .ctrl_m_axis_tlast     (m_tlast),
    .i_dp_bit              (key),
    .i_dp_bit_mask         (keymask),
    .i_dp_bit_valid        (key_vld),
    .o_dp_tcam_match       (match),
    .o_dp_tcam_match_addr  (maddr),
    .o_dp_tcam_match_valid (mvalid)
`ifdef DP_TCAM_STATS_EN
    ,.o_hit_cnt            (hit_cnt)
    ,.o_miss_cnt           (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] hdr(input logic [11:0] id,
                                       input logic [7:0] idx,
                                       input logic vld, input logic clr);
    logic [W-1:0] h;
    h = '0;
    h[W-1 -: 12] = id;
    h[W-13 -: 8] = idx;
    h[W-21]      = vld;
    h[W-22]      = clr;
    return h;
  endfunction

  // Drive one control beat and verify it reappears on ctrl_m one cycle on.
  task automatic beat(input logic [W-1:0] d, input logic last);
    logic [TU-1:0] u;
    logic [W/8-1:0] k;
    u = d[TU-1:0] ^ {TU{1'b1}};
    k = d[W/8-1:0] | 32'h8000_0001;
    s_tdata  = d;
    s_tuser  = u;
    s_tkeep  = k;
    s_tvalid = 1'b1;
    s_tlast  = last;
    tick();
    check("pt_tdata", m_tdata, d);
    check("pt_tuser", W'(m_tuser), W'(u));
    check("pt_ctl", W'({m_tvalid, m_tlast, m_tkeep}), W'({1'b1, last, k}));
  endtask

  task automatic ctrl_idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic write_entry(input logic [7:0] idx, input logic [KW-1:0] v,
                             input logic [KW-1:0] m, input logic vld);
    beat(hdr(12'd8, idx, vld, 1'b0), 1'b0);
    beat(W'(v), 1'b0);
    beat(W'(m), 1'b1);
  endtask

  task automatic set_keys(input logic [KW-1:0] k0, input logic [KW-1:0] m0,
                          input logic [KW-1:0] k1, input logic [KW-1:0] m1);
    key     = {k1, k0};
    keymask = {m1, m0};
    key_vld = 2'b11;
  endtask

  task automatic check_res(input string tag, input logic [1:0] em,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    check({tag, "_match"}, W'(match), W'(em));
    check({tag, "_addr"}, W'(maddr), W'({a1, a0}));
    check({tag, "_valid"}, W'(mvalid), W'(2'b11));
  endtask

  // Full-pipeline lookup: apply, wait 2 cycles, check, then drain.
  task automatic lookup(input string tag,
                        input logic [KW-1:0] k0, input logic [KW-1:0] m0,
                        input logic [KW-1:0] k1, input logic [KW-1:0] m1,
                        input logic [1:0] em, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1);
    set_keys(k0, m0, k1, m1);
    tick();
    key_vld = 2'b00;
    tick();
    check_res(tag, em, a0, a1);
    tick();
    tick();
  endtask

  localparam logic [KW-1:0] ONES = {KW{1'b1}};

  initial begin
    // ---- reset ----
    tick(); tick();
    check("rst_lookup", W'({match, maddr, mvalid}), '0);
    check("rst_ctrl", W'({m_tvalid, m_tlast, m_tkeep}), '0);
    check("rst_tdata", m_tdata, '0);
    rst_n = 1'b1;
    tick();
    check("rst_rel_valid", W'(mvalid), '0);

    // ---- empty table: both channels miss, valid still asserted ----
    lookup("empty", '0, ONES, '0, ONES, 2'b00, 5'd0, 5'd0);

    // ---- entry 5 commit vs lookup in the commit cycle ----
    write_entry(8'd5, 128'hAB, 128'hFF, 1'b1);
    ctrl_idle();
    set_keys(128'h12AB, ONES, 128'h12AC, ONES);   // sampled in commit cycle
    tick();                                       // commit edge
    tick();                                       // commit-cycle key result
    check_res("commit_old", 2'b00, 5'd0, 5'd0);
    tick();
    check_res("commit_new", 2'b01, 5'd5, 5'd0);
    key_vld = 2'b00;
    tick(); tick();
    check("ctrl_idle_out", W'(m_tvalid), W'(1'b0));

    // ---- care-bit boundaries ----
    lookup("keymask0", '0, '0, 128'h0B, 128'h0F, 2'b11, 5'd5, 5'd5);
    lookup("keymask_miss", 128'h12AC, ONES, 128'h00, 128'hF0,
           2'b00, 5'd0, 5'd0);

    // ---- wildcard entry 2 wins by priority ----
    write_entry(8'd2, 128'h0, 128'h0, 1'b1);
    ctrl_idle();
    tick();
    lookup("prio", 128'h12AB, ONES, 128'h9999, ONES, 2'b11, 5'd2, 5'd2);

    // ---- discarded packets, back-to-back: each would plant a wildcard or
    //      matching entry at index 1 if wrongly committed ----
    beat(hdr(12'd8, 8'd1, 1'b1, 1'b0), 1'b0);     // 2-beat, too short
    beat(W'(128'h12AB), 1'b1);
    beat(hdr(12'd9, 8'd1, 1'b1, 1'b0), 1'b0);     // foreign ID
    beat(W'(128'h12AB), 1'b0);
    beat(W'(ONES), 1'b1);
    beat(hdr(12'd8, 8'd33, 1'b1, 1'b0), 1'b0);    // index out of range
    beat(W'(128'h0), 1'b0);
    beat(W'(128'h0), 1'b1);
    ctrl_idle();
    tick();
    lookup("discard", 128'h12AB, ONES, 128'h12AB, ONES, 2'b11, 5'd2, 5'd2);

    // ---- back-to-back: invalidate entry 2, then 4-beat write to entry 3 ----
    write_entry(8'd2, 128'h0, 128'h0, 1'b0);
    beat(hdr(12'd8, 8'd3, 1'b1, 1'b0), 1'b0);
    beat(W'(128'h55), 1'b0);
    beat(W'(128'hFF), 1'b0);
    beat({W{1'b1}}, 1'b1);                        // extra beat ignored
    ctrl_idle();
    tick();
    lookup("b2b", 128'h12AB, ONES, 128'h55, ONES, 2'b11, 5'd5, 5'd3);
    lookup("valid_only", '0, '0, 128'hAC, ONES, 2'b01, 5'd3, 5'd0);

`ifdef DP_TCAM_STATS_EN
    beat(hdr(12'd8, 8'd0, 1'b0, 1'b1), 1'b1);     // clear-only packet
    ctrl_idle();
    tick();
    check("stat_clr_hit", W'(hit_cnt), '0);
    check("stat_clr_miss", W'(miss_cnt), '0);
    set_keys(128'h55, ONES, 128'h55, ONES);       // 2 hits
    tick();
    set_keys(128'h55, ONES, 128'h00, ONES);       // 1 hit, 1 miss
    tick();
    key_vld = 2'b00;
    tick(); tick(); tick();
    check("stat_hit", W'(hit_cnt), W'(32'd3));
    check("stat_miss", W'(miss_cnt), W'(32'd1));
    beat(hdr(12'd8, 8'd0, 1'b0, 1'b1), 1'b1);
    ctrl_idle();
    tick();
    check("stat_clr2", W'({hit_cnt, miss_cnt}), '0);
    lookup("post_clr", 128'h55, ONES, 128'h12AB, ONES, 2'b11, 5'd3, 5'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dp_tcam_lookup_mc.md
# dp_tcam_lookup_mc

Parametrised multi-channel ternary lookup stage for the data-path lookup chain. Holds a TCAM_DEPTH x KEY_WIDTH value/mask table, written in-band by control AXIS packets addressed to CFG_TCAM_MOD_ID. It serves NUM_CH independent key streams against that table every cycle and returns the lowest matching entry per channel. Sits between key extraction and the parser table. Control packets pass through it to the next configuration stage.

## Interface
- C_AXIS_DATA_WIDTH, 256: control bus data width (>= KEY_WIDTH, >= 32).
- C_AXIS_TUSER_WIDTH, 128: control bus tuser width; tuser is passed through only.
- KEY_WIDTH, 128: lookup key width.
- TCAM_DEPTH, 32: number of entries (2..256).
- ADDR_WIDTH, $clog2(TCAM_DEPTH): match address width.
- NUM_CH, 2: number of lookup channels.
- CFG_TCAM_MOD_ID, 8: 12-bit module ID this block answers to.
- axis_clk in 1: clock.
- aresetn in 1: asynchronous active-low reset.
- ctrl_s_axis_tdata/tuser/tkeep/tvalid/tlast in: control stream in (no tready, as for the whole chain).
- ctrl_m_axis_tdata/tuser/tkeep/tvalid/tlast out: control stream out.
- i_dp_bit in NUM_CH*KEY_WIDTH: keys; channel c is at [c*KEY_WIDTH +: KEY_WIDTH].
- i_dp_bit_mask in NUM_CH*KEY_WIDTH: per-key care bits (1 = compare).
- i_dp_bit_valid in NUM_CH: per-channel key strobe.
- o_dp_tcam_match out NUM_CH: hit flag.
- o_dp_tcam_match_addr out NUM_CH*ADDR_WIDTH: lowest hit index.
- o_dp_tcam_match_valid out NUM_CH: result strobe.

## Operation
- Passthrough: every control beat is forwarded unmodified through one register. This includes packets for this block.
- Config packet format:
  - Beat 0 (header): tdata[W-1 -: 12] = module ID; tdata[W-13 -: 8] = entry index; tdata[W-21] = entry valid.
  - Beat 1: tdata[KEY_WIDTH-1:0] = value.
  - Beat 2: tdata[KEY_WIDTH-1:0] = entry mask (1 = care).
  - Beats after 2 are ignored.
- Config FSM states: IDLE, HDR_OK, GOT_VAL, WAIT_LAST.
  - IDLE: on a tvalid beat, if the ID matches and index < TCAM_DEPTH, go to HDR_OK; otherwise go to WAIT_LAST.
  - In any state, a beat with tvalid && tlast returns the FSM to IDLE.
- Staging: value, mask and valid are captured into staging registers. Nothing is written to the live table until commit.
- Commit: one cycle after the tlast beat of a packet that delivered beats 0-2, live entry[index] = staging.
- Discard cases (no commit, table untouched): packet shorter than 3 beats, wrong ID, or index out of range.
- Lookup, channel c, entry e: hit when entry e is valid and ((key ^ value_e) & mask_e & keymask_c) == 0. A masked-out bit always matches; an all-zero mask matches any key.
- Priority: the lowest index wins. With no hit: match = 0 and addr = 0, but valid is still asserted.
- Channels are fully independent. All NUM_CH may be valid in the same cycle.
- Reset values:
  - All outputs 0.
  - Every table entry invalid; value and mask 0.
  - FSM in IDLE.
- Reset mid-packet: the remainder of that packet, seen after reset release, is treated as a packet starting in IDLE. Its first beat is taken as a header.

## Timing
- Control passthrough latency: 1 cycle.
- Lookup latency: 2 cycles, fully pipelined, one key per channel per cycle.
  - Stage 1 registers the NUM_CH x TCAM_DEPTH hit vectors.
  - Stage 2 registers the priority-encoder result.
- Commit vs lookup in the same cycle:
  - A key sampled in the commit cycle sees the old entry.
  - A key sampled one cycle later sees the new entry.
- Back-to-back config packets are accepted with zero gap.

## Configuration
- DP_TCAM_STATS_EN defined: adds o_hit_cnt and o_miss_cnt outputs, each 32 bits.
  - Both count results over all channels; they add popcount per cycle across channels.
  - Both saturate at 0xFFFFFFFF.
  - Both clear on reset, or on a config packet whose header has tdata[W-22] = 1 (a clear-only packet needs no value/mask beats).
- Not defined: the ports, counters and clear bit do not exist, and tdata[W-22] is ignored.

## Structure
- Package dp_lookup_pkg: header field offsets and widths (ID 12, index 8, valid bit, clear bit), FSM state enum.
- Sub-module dp_tcam_prio_enc: TCAM_DEPTH-bit vector -> {hit, ADDR_WIDTH lowest-set index}, combinational.
- One instance of dp_tcam_prio_enc per channel.

## Test plan
- After reset, key 0x0 on both channels -> match = 0, addr = 0, valid 2 cycles later, on both channels.
- Write entry 5: value 0xAB, mask 0xFF, valid. Key 0x12AB, keymask all-ones -> match = 1, addr = 5. Key 0x12AC -> match = 0.
- Also write entry 2 with mask 0 (wildcard). Key 0x12AB -> addr = 2, proving lowest-index priority.
- Send a 2-beat packet to entry 7, then a packet with ID 9 -> no table change. Both packets appear on ctrl_m 1 cycle later, bit-identical.
- Key applied in the commit cycle of entry 5 -> old result. Same key on the next cycle -> addr = 5.
- DP_TCAM_STATS_EN: 3 hits and 1 miss over both channels -> o_hit_cnt = 3, o_miss_cnt = 1. A clear packet zeroes both.
